// File: rtl/result_window_stats.sv
// Accumulates a window of (x, z) samples and reports sum(x), max(z), min(z) and the count.
// The summary is held until the sink acknowledges it; a flush closes a partial window early.
module result_window_stats #(
  parameter int unsigned XWIDTH   = 16,
  parameter int unsigned ZWIDTH   = 8,
  parameter int unsigned WINDOW   = 8,
  parameter int unsigned SUMWIDTH = 24
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [XWIDTH-1:0]   x_i,
  input  logic [ZWIDTH-1:0]   z_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [SUMWIDTH-1:0] sum_x_o,
  output logic [ZWIDTH-1:0]   max_z_o,
  output logic [ZWIDTH-1:0]   min_z_o,
  output logic [7:0]          count_o
);

  // state  | meaning
  // ACCUM  | accepting samples, running statistics visible on the outputs
  // REPORT | summary held, waiting for out_ready_i
  typedef enum logic {ACCUM, REPORT} state_e;

  state_e              state_q;
  logic [SUMWIDTH-1:0] sum_q, sum_d;
  logic [ZWIDTH-1:0]   max_q, max_d, min_q, min_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                out_valid_q, in_ready_q;
  logic                accept, close;

  assign accept = (state_q == ACCUM) && in_valid_i;

  always_comb begin
    sum_d = sum_q;
    max_d = max_q;
    min_d = min_q;
    cnt_d = cnt_q;
    if (accept) begin
      sum_d = sum_q + SUMWIDTH'(x_i);
      if (z_i > max_q) max_d = z_i;
      if (z_i < min_q) min_d = z_i;
      cnt_d = cnt_q + 8'd1;
    end
  end

  // A same-cycle acceptance is already folded into cnt_d, so flush sees the final count.
  assign close = (state_q == ACCUM) &&
                 ((accept && (cnt_d == 8'(WINDOW))) || (flush_i && (cnt_d != 8'd0)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      max_q       <= '0;
      min_q       <= '1;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ACCUM: begin
          sum_q <= sum_d;
          max_q <= max_d;
          min_q <= min_d;
          cnt_q <= cnt_d;
          if (close) begin
            state_q     <= REPORT;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
          end
        end
        REPORT: begin
          if (out_ready_i) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            max_q       <= '0;
            min_q       <= '1;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign sum_x_o     = sum_q;
  assign max_z_o     = max_q;
  assign min_z_o     = min_q;
  assign count_o     = cnt_q;

endmodule

// File: tb/tb_result_window_stats.sv
// Scoreboard bench for result_window_stats: a window-level reference model queues expected
// summaries while a negedge monitor compares every presented output against it.
module tb_result_window_stats;

  localparam int WINDOW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [15:0] x = '0;
  logic [7:0]  z = '0;
  logic        in_ready, out_valid;
  logic [23:0] sum_x;
  logic [7:0]  max_z, min_z, count;

  result_window_stats #(.XWIDTH(16), .ZWIDTH(8), .WINDOW(WINDOW), .SUMWIDTH(24)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .x_i(x), .z_i(z), .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_x_o(sum_x), .max_z_o(max_z), .min_z_o(min_z), .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int mx; int mn; int c; } summ_t;
  typedef struct { int x; int z; } samp_t;

  summ_t exp_q[$];
  samp_t win[$];
  bit    m_report = 1'b0;
  bit    mon_en = 1'b0;
  int    tests = 0, fails = 0;
  int    last_s = -1, last_mx = -1, last_mn = -1, last_c = -1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic summ_t summarize();
    summ_t r;
    r.s = 0; r.mx = 0; r.mn = 255; r.c = win.size();
    foreach (win[i]) begin
      r.s += win[i].x;
      if (win[i].z > r.mx) r.mx = win[i].z;
      if (win[i].z < r.mn) r.mn = win[i].z;
    end
    return r;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then advance the reference model.
  task automatic step(input bit iv, input int xv, input int zv, input bit fl, input bit ordy);
    in_valid = iv; x = 16'(xv); z = 8'(zv); flush = fl; out_ready = ordy;
    @(posedge clk);
    if (!m_report) begin
      if (iv) win.push_back('{x: xv, z: zv});
      if (win.size() == WINDOW || (fl && win.size() >= 1)) begin
        exp_q.push_back(summarize());
        m_report = 1'b1;
      end
    end else if (ordy) begin
      m_report = 1'b0;
      win.delete();
    end
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sum_x"}, sum_x, 0);
    chk({tag, "_max_z"}, max_z, 0);
    chk({tag, "_min_z"}, min_z, 255);
    chk({tag, "_count"}, count, 0);
  endtask

  task automatic drain();
    int guard = 0;
    while (m_report && guard < 10) begin
      step(0, 0, 0, 0, 1);
      guard++;
    end
    chk("drain_done", int'(m_report), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", out_valid, int'(m_report));
      chk("in_ready", in_ready, int'(!m_report));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_summary", 1, 0);
        end else begin
          chk("sum_x", sum_x, exp_q[0].s);
          chk("max_z", max_z, exp_q[0].mx);
          chk("min_z", min_z, exp_q[0].mn);
          chk("count", count, exp_q[0].c);
          if (out_ready) begin
            last_s = exp_q[0].s; last_mx = exp_q[0].mx;
            last_mn = exp_q[0].mn; last_c = exp_q[0].c;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        summ_t p;
        p = summarize();
        chk("run_sum_x", sum_x, p.s);
        chk("run_max_z", max_z, p.mx);
        chk("run_min_z", min_z, p.mn);
        chk("run_count", count, p.c);
      end
    end
  end

  initial begin
    int zs[8] = '{5, 200, 17, 0, 99, 255, 3, 128};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_values("reset");
    mon_en = 1'b1;

    // Full window back-to-back with the sink always ready
    for (int i = 0; i < 8; i++) step(1, 1000 + i, zs[i], 0, 1);
    step(0, 0, 0, 0, 1);
    chk("full_sum", last_s, 8028);
    chk("full_max", last_mx, 255);
    chk("full_min", last_mn, 0);
    chk("full_cnt", last_c, 8);

    // Same window held under backpressure while upstream keeps offering samples
    for (int i = 0; i < 8; i++) step(1, 1000 + i, zs[i], 0, 0);
    for (int i = 0; i < 5; i++) step(1, 7, 9, 0, 0);
    chk("bp_held_count", count, 8);
    step(1, 7, 9, 0, 1);
    step(1, 42, 11, 0, 1);
    chk("bp_restart_count", count, 1);
    chk("bp_restart_sum", sum_x, 42);
    step(0, 0, 0, 1, 1);
    drain();

    // Flush together with the third sample
    step(1, 16'hFFFF, 7, 0, 1);
    step(1, 16'hFFFF, 7, 0, 1);
    step(1, 16'hFFFF, 7, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("flush_sum", last_s, 196605);
    chk("flush_max", last_mx, 7);
    chk("flush_min", last_mn, 7);
    chk("flush_cnt", last_c, 3);

    // Flush on an empty window is ignored
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("empty_flush_valid", out_valid, 0);

    // Asynchronous reset in the middle of a window
    for (int i = 0; i < 4; i++) step(1, 300 + i, 50 + i, 0, 1);
    in_valid = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    win.delete(); exp_q.delete(); m_report = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("post_reset_sum", last_s, 8);
    chk("post_reset_cnt", last_c, 8);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 65535), $urandom_range(0, 255),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/result_window_stats.md
# result_window_stats

Downstream consumer of the circuit1 datapath outputs (16-bit `x`, 8-bit `z`). Accepts one (x, z) pair per cycle over a valid/ready handshake and accumulates a window of WINDOW samples. At the end of the window it presents a summary: sum of x, max and min of z, and sample count. It then holds the summary until the sink acknowledges it. An early flush closes a partial window.

## Interface
- XWIDTH, 16, width of `x` input (unsigned)
- ZWIDTH, 8, width of `z` input (unsigned)
- WINDOW, 8, samples per full window; legal range 1..255
- SUMWIDTH, 24, width of `sum_x`; must be ≥ XWIDTH + clog2(WINDOW+1)

- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample this cycle
- x  in  XWIDTH  sample x value
- z  in  ZWIDTH  sample z value
- flush  in  1  close current window early (level, sampled each cycle)
- out_valid  out  1  summary valid
- out_ready  in  1  sink accepts summary
- sum_x  out  SUMWIDTH  unsigned sum of accepted x in window
- max_z  out  ZWIDTH  largest accepted z (unsigned)
- min_z  out  ZWIDTH  smallest accepted z (unsigned)
- count  out  8  number of samples in window

## Operation
- Two-state FSM: ACCUM, REPORT. Reset state: ACCUM.
- Reset values: in_ready=1, out_valid=0, sum_x=0, max_z=0, min_z=all ones, count=0.
- ACCUM behaviour:
  - in_ready=1 and out_valid=0.
  - A sample is accepted when in_valid=1 in ACCUM.
  - On acceptance: sum_x += x (zero-extended), max_z = max(max_z, z), min_z = min(min_z, z), count += 1. All comparisons unsigned.
- ACCUM→REPORT transition occurs on either of:
  - an acceptance that makes count == WINDOW;
  - flush=1 when count (after including a same-cycle acceptance) ≥ 1.
- flush=1 with count=0 and no acceptance: ignored; stay in ACCUM.
- flush and acceptance in the same cycle: the sample is included in the summary.
- REPORT behaviour:
  - in_ready=0 and out_valid=1.
  - Summary registers hold stable; in_valid and flush are ignored.
- REPORT→ACCUM when out_ready=1. On the same edge: sum_x=0, max_z=0, min_z=all ones, count=0.
- Sum never overflows under legal parameters; no saturation logic.
- Async reset mid-window or mid-REPORT discards all state immediately and returns to reset values.

## Timing
- Accept rate: 1 sample/cycle in ACCUM; 0 in REPORT.
- Summary latency: out_valid rises the cycle after the edge that accepts the final sample (or the flush edge).
- Outputs are registered; no combinational path from in_valid or out_ready to any output.
- Minimum window period: WINDOW cycles of accumulation, plus 1 REPORT cycle when out_ready is held high.
- Back-to-back windows:
  - With out_ready=1 continuously, REPORT lasts exactly 1 cycle.
  - in_ready returns to 1 on the following cycle.
  - The first sample of the next window can be accepted in that cycle.
- out_ready asserted while in ACCUM has no effect.

## Test plan
- Reset check: hold Rst=0 for 3 cycles, then release. Required: in_ready=1, out_valid=0, sum_x=0, max_z=0, min_z=0xFF, count=0.
- Full window: WINDOW=8, out_ready=1, stream x=1000..1007 and z=5,200,17,0,99,255,3,128 back-to-back.
  - out_valid=1 for exactly 1 cycle, the cycle after the 8th acceptance.
  - Summary: sum_x=8028, max_z=255, min_z=0, count=8.
  - in_ready=0 in that cycle only.
- Backpressure: same window with out_ready=0 for 5 cycles after out_valid rises, while in_valid=1 throughout.
  - Summary stable, in_ready=0, no samples accepted.
  - After out_ready=1, the next sample is accepted the following cycle with count restarting at 1.
- Flush: accept 3 samples (x=0xFFFF ×3, z=7,7,7), asserting flush together with the 3rd sample. Required summary: sum_x=196605, max_z=7, min_z=7, count=3.
  - Separately, flush with count=0 and in_valid=0 produces no out_valid.
- Reset mid-window: accept 4 samples, then pulse Rst low asynchronously between clock edges. Required: outputs return to reset values immediately.
  - A subsequent full window of x=1 ×8 reports sum_x=8, count=8.
